// File: rtl/mult_seq_ctrl_pkg.sv
// Shared definitions for the sequential 4x4 shift-and-add multiplier.
// Holds the controller state encoding, the operand/product widths and the
// iteration count used by both the controller and its adder.
package mult_seq_ctrl_pkg;

  localparam int OPW  = 4;
  localparam int PW   = 8;
  localparam int ITER = 4;

  // Iteration counter width and the count value that marks the final pass.
  localparam int            CW       = $clog2(ITER);
  localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_seq_ctrl_adder.sv
// Plain unsigned PW-bit adder shared by the multiplier datapath.
// Ports:
//   a, b       : PW-bit unsigned operands
//   out        : PW-bit sum (modulo 2^PW)
//   carry_out  : carry out of the top bit
module mult_seq_ctrl_adder
  import mult_seq_ctrl_pkg::*;
(
  input  logic [PW-1:0] a,
  input  logic [PW-1:0] b,
  output logic [PW-1:0] out,
  output logic          carry_out
);

  // Widen by one bit so the carry falls out of the same addition.
  assign {carry_out, out} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential 4x4 unsigned multiplier using one shift-and-add pass per
// multiplier bit. A start seen in IDLE captures the operands, four CALC
// cycles accumulate partial products, and DONE pulses for one cycle while
// product presents the new result. product holds the last result until the
// next completion or a reset.
// Ports:
//   clk      : system clock, all state changes on the rising edge
//   rst      : synchronous active-high reset
//   start    : request to multiply, only looked at in IDLE
//   a, b     : 4-bit unsigned multiplicand and multiplier
//   busy     : high while the multiply is in progress (CALC)
//   done     : single-cycle completion pulse (DONE)
//   product  : registered 8-bit result of the last completed multiply
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [PW-1:0]  product
);

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [OPW-1:0]  mplr_q, mplr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   product_q, product_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [PW-1:0]   addend;
  logic [PW-1:0]   adder_out;
  // Carry can never be set for 4x4 operands, so it is deliberately dropped.
  logic            adder_carry_unused;

  // The partial product for this pass is the shifted multiplicand when the
  // current low multiplier bit is set, otherwise nothing.
  assign addend = mplr_q[0] ? mcand_q : '0;

  mult_seq_ctrl_adder u_adder (
    .a         (acc_q),
    .b         (addend),
    .out       (adder_out),
    .carry_out (adder_carry_unused)
  );

  // Next-state and datapath logic. busy/done are decoded from the next
  // state so that their flops line up exactly with the state register.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          mcand_d = {{(PW-OPW){1'b0}}, a};
          mplr_d  = b;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      CALC: begin
        acc_d   = adder_out;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        // The last pass publishes the sum directly rather than waiting a
        // cycle for acc, so product is valid in the same cycle as done.
        if (cnt_q == LAST_CNT) begin
          state_d   = DONE;
          product_d = adder_out;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  // Single register bank for controller and datapath; reset clears
  // everything, including the last published product.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl. The reference model is simply the
// product a*b plus the fixed timing profile of an operation: busy for four
// cycles after the accepting edge, done in the fifth, idle in the sixth.
module tb_mult_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int checks = 0;
  int errors = 0;

  // Model of the value product must currently show.
  logic [7:0] exp_product;

  always #5 clk = ~clk;

  mult_seq_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Advance one rising edge and settle before anyone samples outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation from the accepting edge to the return to IDLE.
  // With noise set, start and operands are randomised while the block is
  // busy; none of that may disturb the result or the timing.
  task automatic run_op(input logic [3:0] op_a, input logic [3:0] op_b, input bit noise);
    logic [7:0] result;
    logic       exp_busy;
    logic       exp_done;
    result = 8'(int'(op_a) * int'(op_b));
    start = 1'b1;
    a = op_a;
    b = op_b;
    tick();
    for (int i = 0; i < 6; i++) begin
      exp_busy = (i <= 3);
      exp_done = (i == 4);
      if (i == 4) exp_product = result;
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("[TB] FAIL busy %0d*%0d cyc%0d got %b want %b", op_a, op_b, i, busy, exp_busy);
      end
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("[TB] FAIL done %0d*%0d cyc%0d got %b want %b", op_a, op_b, i, done, exp_done);
      end
      checks++;
      if (product !== exp_product) begin
        errors++;
        $display("[TB] FAIL product %0d*%0d cyc%0d got %h want %h", op_a, op_b, i, product, exp_product);
      end
      checks++;
      if (dut.u_adder.carry_out !== 1'b0) begin
        errors++;
        $display("[TB] FAIL carry %0d*%0d cyc%0d got %b want 0", op_a, op_b, i, dut.u_adder.carry_out);
      end
      if (i < 5) begin
        start = noise ? 1'($urandom) : 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
        tick();
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    a = 4'd5;
    b = 4'd5;
    repeat (3) tick();
    rst = 1'b0;
    start = 1'b0;
    exp_product = 8'h00;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags got busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (product !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_product got %h want 00", product);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    run_op(4'd13, 4'd11, 1'b0);
    checks++;
    if (product !== 8'h8F) begin
      errors++;
      $display("[TB] FAIL dir_13x11 got %h want 8f", product);
    end
    run_op(4'd15, 4'd15, 1'b0);
    checks++;
    if (product !== 8'hE1) begin
      errors++;
      $display("[TB] FAIL dir_15x15 got %h want e1", product);
    end
    run_op(4'd0, 4'd9, 1'b0);
    checks++;
    if (product !== 8'h00) begin
      errors++;
      $display("[TB] FAIL dir_0x9 got %h want 00", product);
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    dones = 0;
    start = 1'b1;
    a = 4'd6;
    b = 4'd7;
    tick();
    // Fresh requests with other operands throughout CALC and DONE.
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) dones++;
      start = 1'b1;
      a = 4'd15;
      b = 4'd14;
      tick();
    end
    start = 1'b0;
    if (done === 1'b1) dones++;
    repeat (6) begin
      tick();
      if (done === 1'b1) dones++;
    end
    exp_product = 8'd42;
    checks++;
    if (product !== exp_product) begin
      errors++;
      $display("[TB] FAIL ignore_product got %h want %h", product, exp_product);
    end
    // Start is still high when DONE returns to IDLE, so it is not a second
    // request; exactly one completion is expected from the whole window.
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("[TB] FAIL ignore_dones got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    dones = 0;
    start = 1'b1;
    a = 4'd7;
    b = 4'd6;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_product = 8'h00;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_flags got busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (product !== 8'h00) begin
      errors++;
      $display("[TB] FAIL abort_product got %h want 00", product);
    end
    repeat (6) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("[TB] FAIL abort_activity got %0d cycles want 0", dones);
    end
    run_op(4'd7, 4'd6, 1'b0);
    checks++;
    if (product !== 8'h2A) begin
      errors++;
      $display("[TB] FAIL abort_rerun got %h want 2a", product);
    end
  endtask

  task automatic test_back_to_back();
    int first_done;
    int second_done;
    logic exp_busy;
    logic exp_done;
    first_done = -1;
    second_done = -1;
    start = 1'b1;
    a = 4'd3;
    b = 4'd5;
    tick();
    // Operands change while start stays high; only the re-accept sees them.
    a = 4'd9;
    b = 4'd9;
    for (int i = 0; i < 11; i++) begin
      exp_busy = ((i % 6) <= 3);
      exp_done = ((i % 6) == 4);
      if (i == 4)  exp_product = 8'h0F;
      if (i == 10) exp_product = 8'h51;
      if (done === 1'b1) begin
        if (first_done < 0) first_done = i;
        else second_done = i;
      end
      checks++;
      if (busy !== exp_busy || done !== exp_done) begin
        errors++;
        $display("[TB] FAIL b2b_flags cyc%0d got busy=%b done=%b want %b %b", i, busy, done, exp_busy, exp_done);
      end
      checks++;
      if (product !== exp_product) begin
        errors++;
        $display("[TB] FAIL b2b_product cyc%0d got %h want %h", i, product, exp_product);
      end
      if (i < 10) tick();
    end
    start = 1'b0;
    checks++;
    if (second_done - first_done !== 6) begin
      errors++;
      $display("[TB] FAIL b2b_spacing got %0d want 6", second_done - first_done);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h51) begin
      errors++;
      $display("[TB] FAIL b2b_end got busy=%b done=%b product=%h want 0 0 51", busy, done, product);
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 256; i++) begin
      run_op(4'(i >> 4), 4'(i), 1'($urandom));
    end
  endtask

  task automatic test_random_gaps();
    for (int n = 0; n < 20; n++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== exp_product) begin
          errors++;
          $display("[TB] FAIL gap_idle got busy=%b done=%b product=%h want 0 0 %h", busy, done, product, exp_product);
        end
      end
      run_op(4'($urandom), 4'($urandom), 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = 4'd0;
    b = 4'd0;
    exp_product = 8'h00;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_sweep();
    test_random_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
